// File: rtl/disp_pixout.sv
// Display pixel output stage: paces FIFO reads against the sync generator counters,
// delays pixels and syncs by two cycles, and tracks FIFO underflow.
module disp_pixout #(
  parameter int unsigned HDISP   = 1024,
  parameter int unsigned VDISP   = 768,
  parameter int unsigned HPERIOD = 1344,
  parameter int unsigned VPERIOD = 806
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [10:0] HCNT,
  input  logic [9:0]  VCNT,
  input  logic        HS_IN,
  input  logic        VS_IN,
  input  logic [23:0] FIFO_DOUT,
  input  logic        FIFO_EMPTY,
  output logic        FIFO_RD,
  output logic        FIFO_FLUSH,
  output logic        FRAME_REQ,
  input  logic        CLR_ERR,
  output logic [4:0]  VGA_R,
  output logic [5:0]  VGA_G,
  output logic [4:0]  VGA_B,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_DE,
  output logic        UNDERFLOW,
  output logic [15:0] UFCNT
);

  localparam logic [10:0] HDispW  = 11'(HDISP);
  localparam logic [9:0]  VDispW  = 10'(VDISP);
  localparam logic [10:0] HLastW  = 11'(HPERIOD - 1);
  localparam logic [9:0]  VLastW  = 10'(VPERIOD - 1);

  typedef enum logic [1:0] {StIdle, StWait, StRun, StResync} state_e;

  state_e state_q;
  logic   disp_en;
  logic   req_pt;
  logic   start_pt;
  logic   underflow_ev;
  logic   en_s1;
  logic   vld_s1;
  logic   hs_s1;
  logic   vs_s1;

  assign disp_en  = (HCNT < HDispW) && (VCNT < VDispW);
  assign req_pt   = (HCNT == 11'd0) && (VCNT == VDispW);
  assign start_pt = (HCNT == HLastW) && (VCNT == VLastW);

  // Reset gates the strobe combinationally so an in-flight read is aborted at once.
  assign FIFO_RD      = !RST && (state_q == StRun) && disp_en && !FIFO_EMPTY;
  assign underflow_ev = !RST && (state_q == StRun) && disp_en && FIFO_EMPTY;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= StIdle;
      FRAME_REQ  <= 1'b0;
      FIFO_FLUSH <= 1'b0;
    end else begin
      FRAME_REQ  <= 1'b0;
      FIFO_FLUSH <= 1'b0;
      unique case (state_q)
        StIdle, StResync: begin
          if (req_pt) begin
            FRAME_REQ  <= 1'b1;
            FIFO_FLUSH <= 1'b1;
            state_q    <= StWait;
          end
        end
        StWait: begin
          if (start_pt) state_q <= StRun;
        end
        StRun: begin
          if (underflow_ev) begin
            state_q <= StResync;
          end else if (req_pt) begin
            FRAME_REQ <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Two-stage pixel pipeline; FIFO data arrives the cycle after the strobe.
  always_ff @(posedge CLK) begin
    if (RST) begin
      en_s1  <= 1'b0;
      vld_s1 <= 1'b0;
      VGA_DE <= 1'b0;
      VGA_R  <= '0;
      VGA_G  <= '0;
      VGA_B  <= '0;
    end else begin
      en_s1  <= disp_en;
      vld_s1 <= FIFO_RD;
      VGA_DE <= en_s1;
      VGA_R  <= vld_s1 ? FIFO_DOUT[23:19] : 5'd0;
      VGA_G  <= vld_s1 ? FIFO_DOUT[15:10] : 6'd0;
      VGA_B  <= vld_s1 ? FIFO_DOUT[7:3]   : 5'd0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      hs_s1  <= 1'b1;
      vs_s1  <= 1'b1;
      VGA_HS <= 1'b1;
      VGA_VS <= 1'b1;
    end else begin
      hs_s1  <= HS_IN;
      vs_s1  <= VS_IN;
      VGA_HS <= hs_s1;
      VGA_VS <= vs_s1;
    end
  end

  // A new underflow overrides a coincident clear.
  always_ff @(posedge CLK) begin
    if (RST) begin
      UNDERFLOW <= 1'b0;
      UFCNT     <= '0;
    end else begin
      if (underflow_ev) begin
        UNDERFLOW <= 1'b1;
        if (UFCNT != 16'hFFFF) UFCNT <= UFCNT + 16'd1;
      end else if (CLR_ERR) begin
        UNDERFLOW <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_disp_pixout.sv
// Randomized bench for disp_pixout on a shrunken raster, checked against a frame-level model.
module tb_disp_pixout;

  localparam int HD = 8;
  localparam int VD = 6;
  localparam int HP = 12;
  localparam int VP = 9;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [10:0] HCNT = '0;
  logic [9:0]  VCNT = '0;
  logic        HS_IN = 1'b1;
  logic        VS_IN = 1'b1;
  logic [23:0] FIFO_DOUT = '0;
  logic        FIFO_EMPTY = 1'b0;
  logic        CLR_ERR = 1'b0;
  logic        FIFO_RD, FIFO_FLUSH, FRAME_REQ;
  logic [4:0]  VGA_R;
  logic [5:0]  VGA_G;
  logic [4:0]  VGA_B;
  logic        VGA_HS, VGA_VS, VGA_DE, UNDERFLOW;
  logic [15:0] UFCNT;

  always #5 CLK = ~CLK;

  disp_pixout #(.HDISP(HD), .VDISP(VD), .HPERIOD(HP), .VPERIOD(VP)) dut (
    .CLK(CLK), .RST(RST), .HCNT(HCNT), .VCNT(VCNT), .HS_IN(HS_IN), .VS_IN(VS_IN),
    .FIFO_DOUT(FIFO_DOUT), .FIFO_EMPTY(FIFO_EMPTY), .FIFO_RD(FIFO_RD),
    .FIFO_FLUSH(FIFO_FLUSH), .FRAME_REQ(FRAME_REQ), .CLR_ERR(CLR_ERR),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
    .VGA_DE(VGA_DE), .UNDERFLOW(UNDERFLOW), .UFCNT(UFCNT)
  );

  int n_checks = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Model: "armed" = frame requested, awaiting start; "streaming" = frame being shown.
  bit m_armed = 0, m_stream = 0, m_sticky = 0;
  int m_cnt = 0;
  bit p_en = 0, p_rd = 0, p_hs = 1, p_vs = 1;
  bit force_word = 0;
  int h = 0, v = 0;
  int f_rd = 0, f_req = 0, f_flush = 0;

  task automatic tick(input bit rst, input bit empty, input bit clr);
    bit en, rd, req, start, uf, hs, vs, x_req, x_flush, x_de, x_hs, x_vs;
    logic [23:0] dout, x_pix;
    hs   = 1'($urandom_range(0, 1));
    vs   = 1'($urandom_range(0, 1));
    dout = force_word ? 24'hFF8001 : 24'($urandom);
    @(negedge CLK);
    RST = rst; HCNT = 11'(h); VCNT = 10'(v); FIFO_EMPTY = empty; CLR_ERR = clr;
    HS_IN = hs; VS_IN = vs; FIFO_DOUT = dout;
    en    = (h < HD) && (v < VD);
    req   = (h == 0) && (v == VD);
    start = (h == HP - 1) && (v == VP - 1);
    rd    = !rst && m_stream && en && !empty;
    uf    = !rst && m_stream && en && empty;
    #2;
    check_eq("fifo_rd", 32'(FIFO_RD), 32'(rd));
    f_rd += int'(FIFO_RD);
    @(posedge CLK);
    #1;
    x_req   = !rst && req && !m_armed;
    x_flush = x_req && !m_stream;
    x_de    = !rst && p_en;
    x_pix   = (!rst && p_rd) ? dout : 24'd0;
    x_hs    = rst ? 1'b1 : p_hs;
    x_vs    = rst ? 1'b1 : p_vs;
    if (rst) begin
      m_armed = 0; m_stream = 0; m_sticky = 0; m_cnt = 0;
    end else begin
      if (uf) begin
        m_sticky = 1;
        if (m_cnt < 65535) m_cnt++;
      end else if (clr) begin
        m_sticky = 0;
      end
      if (m_stream) begin
        if (uf) m_stream = 0;
      end else if (m_armed) begin
        if (start) begin m_armed = 0; m_stream = 1; end
      end else if (req) begin
        m_armed = 1;
      end
    end
    check_eq("frame_req", 32'(FRAME_REQ), 32'(x_req));
    check_eq("fifo_flush", 32'(FIFO_FLUSH), 32'(x_flush));
    check_eq("underflow", 32'(UNDERFLOW), 32'(m_sticky));
    check_eq("ufcnt", 32'(UFCNT), 32'(m_cnt));
    check_eq("vga_de", 32'(VGA_DE), 32'(x_de));
    check_eq("vga_rgb", 32'({VGA_R, VGA_G, VGA_B}),
             32'({x_pix[23:19], x_pix[15:10], x_pix[7:3]}));
    check_eq("vga_hs", 32'(VGA_HS), 32'(x_hs));
    check_eq("vga_vs", 32'(VGA_VS), 32'(x_vs));
    if (force_word && h == 1 && v == 0) begin
      check_eq("first_px_de", 32'(VGA_DE), 32'd1);
      check_eq("first_px_r", 32'(VGA_R), 32'h1F);
      check_eq("first_px_g", 32'(VGA_G), 32'h20);
      check_eq("first_px_b", 32'(VGA_B), 32'h00);
    end
    f_req   += int'(FRAME_REQ);
    f_flush += int'(FIFO_FLUSH);
    p_en = !rst && en;
    p_rd = rd;
    p_hs = rst ? 1'b1 : hs;
    p_vs = rst ? 1'b1 : vs;
    h++;
    if (h == HP) begin
      h = 0;
      v = (v == VP - 1) ? 0 : v + 1;
    end
  endtask

  task automatic run_frame(input int eh, input int ev, input bit clr_at_uf, input bit clr_start);
    bit empty, clr;
    f_rd = 0; f_req = 0; f_flush = 0;
    for (int i = 0; i < HP * VP; i++) begin
      empty = (h == eh) && (v == ev);
      clr   = (clr_at_uf && empty) || (clr_start && h == 0 && v == 0);
      tick(1'b0, empty, clr);
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0);
    check_eq("rst_hs", 32'(VGA_HS), 32'd1);
    check_eq("rst_de", 32'(VGA_DE), 32'd0);
    h = 0; v = 0;

    run_frame(-1, -1, 1'b0, 1'b0);
    check_eq("idle_reads", 32'(f_rd), 32'd0);
    check_eq("idle_req", 32'(f_req), 32'd1);
    check_eq("idle_flush", 32'(f_flush), 32'd1);

    force_word = 1;
    run_frame(-1, -1, 1'b0, 1'b0);
    force_word = 0;
    check_eq("run_reads", 32'(f_rd), 32'(HD * VD));
    check_eq("run_req", 32'(f_req), 32'd1);
    check_eq("run_flush", 32'(f_flush), 32'd0);

    run_frame(3, 2, 1'b0, 1'b0);
    check_eq("uf_reads", 32'(f_rd), 32'(2 * HD + 3));
    check_eq("uf_req", 32'(f_req), 32'd1);
    check_eq("uf_flush", 32'(f_flush), 32'd1);
    check_eq("uf_flag", 32'(UNDERFLOW), 32'd1);
    check_eq("uf_cnt", 32'(UFCNT), 32'd1);

    run_frame(-1, -1, 1'b0, 1'b0);
    check_eq("resume_reads", 32'(f_rd), 32'(HD * VD));

    run_frame(5, 4, 1'b1, 1'b0);
    check_eq("uf2_reads", 32'(f_rd), 32'(4 * HD + 5));
    check_eq("uf2_flag", 32'(UNDERFLOW), 32'd1);
    check_eq("uf2_cnt", 32'(UFCNT), 32'd2);

    run_frame(-1, -1, 1'b0, 1'b1);
    check_eq("clr_reads", 32'(f_rd), 32'(HD * VD));
    check_eq("clr_flag", 32'(UNDERFLOW), 32'd0);
    check_eq("clr_cnt", 32'(UFCNT), 32'd2);

    // Mid-line reset while streaming.
    for (int i = 0; i < HP + 4; i++) tick(1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    check_eq("midrst_hs", 32'(VGA_HS), 32'd1);
    check_eq("midrst_cnt", 32'(UFCNT), 32'd0);

    for (int i = 0; i < 20 * HP * VP; i++) begin
      tick(($urandom_range(0, 399) == 0),
           ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 29) == 0));
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/disp_pixout.md
DISP_PIXOUT -- requirements
Module: disp_pixout

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  HDISP, 1024, active pixels per line
  VDISP, 768, active lines per frame
  HPERIOD, 1344, total pixel clocks per line
  VPERIOD, 806, total lines per frame
REQ-002 Ports (name, direction, width, meaning), clock and reset first:
  CLK  in  1  pixel clock, the same clock that drives the sync generator counters
  RST  in  1  synchronous, active-high reset
  HCNT  in  11  horizontal counter from the sync generator
  VCNT  in  10  vertical counter from the sync generator
  HS_IN  in  1  horizontal sync from the sync generator, active low
  VS_IN  in  1  vertical sync from the sync generator, active low
  FIFO_DOUT  in  24  pixel word {R[23:16], G[15:8], B[7:0]}
  FIFO_EMPTY  in  1  pixel FIFO empty flag
  FIFO_RD  out  1  FIFO read strobe; data is valid the cycle after the strobe
  FIFO_FLUSH  out  1  one-cycle FIFO clear pulse
  FRAME_REQ  out  1  one-cycle pulse requesting the upstream reader to fetch the next frame
  CLR_ERR  in  1  clears UNDERFLOW
  VGA_R  out  5  red, R[23:19]
  VGA_G  out  6  green, G[15:10]
  VGA_B  out  5  blue, B[7:3]
  VGA_HS  out  1  delayed HS_IN
  VGA_VS  out  1  delayed VS_IN
  VGA_DE  out  1  display enable, aligned with the RGB outputs
  UNDERFLOW  out  1  sticky underflow flag
  UFCNT  out  16  underflow event counter, saturating

Function
REQ-003 disp_en SHALL be (HCNT < HDISP) and (VCNT < VDISP), evaluated combinationally on the current inputs.
REQ-004 The request point SHALL be HCNT==0 and VCNT==VDISP.
REQ-005 The start point SHALL be HCNT==HPERIOD-1 and VCNT==VPERIOD-1.
REQ-006 The FSM SHALL have four states: IDLE, WAIT, RUN and RESYNC.
REQ-007 IDLE: at the request point, pulse FRAME_REQ and FIFO_FLUSH for one cycle and go to WAIT.
REQ-008 WAIT: at the start point, go to RUN; issue no reads while in WAIT.
REQ-009 RUN: FIFO_RD SHALL be disp_en and not FIFO_EMPTY, combinational on the current inputs.
REQ-010 RUN: at the request point, pulse FRAME_REQ (no flush) and stay in RUN.
REQ-011 RUN: if disp_en and FIFO_EMPTY in the same cycle, an underflow occurs and the FSM goes to RESYNC.
REQ-012 RESYNC: issue no reads; at the request point, pulse FRAME_REQ and FIFO_FLUSH together and go to WAIT.
REQ-013 Pixel pipeline latency SHALL be exactly 2 cycles from HCNT/VCNT to RGB/DE:
  stage 1 registers disp_en and a valid bit (FIFO_RD asserted);
  stage 2 registers RGB = FIFO_DOUT if valid, else zero, and DE = stage-1 disp_en.
REQ-014 HS_IN and VS_IN SHALL each pass through a 2-stage shift register so they stay aligned with RGB/DE.
REQ-015 Every pixel with DE high but no read (underflow, WAIT, RESYNC, IDLE) SHALL output black.
REQ-016 Every pixel with DE low SHALL output black.
REQ-017 On an underflow, UNDERFLOW SHALL set and UFCNT SHALL increment by 1, saturating at 16'hFFFF.
REQ-018 Only the first empty pixel of an underflow is counted, because the FSM leaves RUN on it.
REQ-019 CLR_ERR SHALL clear UNDERFLOW only; UFCNT is cleared only by RST.
REQ-020 If CLR_ERR coincides with a new underflow, set SHALL win.
REQ-021 FRAME_REQ and FIFO_FLUSH SHALL be registered outputs, high for exactly one cycle, in the cycle after the request point is sampled.
REQ-022 The request point lies outside the active area, so it SHALL never coincide with an underflow; no priority rule is needed between them.

Reset
REQ-023 While RST is high: FSM goes to IDLE.
REQ-024 While RST is high: FIFO_RD, FIFO_FLUSH, FRAME_REQ, VGA_DE, RGB, UNDERFLOW and UFCNT are all 0.
REQ-025 While RST is high: VGA_HS, VGA_VS and both sync pipeline stages are 1.
REQ-026 A reset asserted mid-frame SHALL abort any read immediately and drop the stage-1 valid bit.
REQ-027 After reset, no pixel data SHALL be read before the next request point plus start point.

Verification
REQ-028 Reset release at HCNT=0, VCNT=0:
  -> FIFO_RD stays 0 until a full IDLE, WAIT, RUN sequence completes;
  -> FRAME_REQ and FIFO_FLUSH pulse one cycle after HCNT=0, VCNT=768.
REQ-029 RUN with FIFO never empty and FIFO_DOUT=24'hFF8001 at HCNT=0, VCNT=0:
  -> two cycles later VGA_DE=1, VGA_R=5'h1F, VGA_G=6'h20, VGA_B=5'h00.
REQ-030 RUN, full frame:
  -> exactly 786432 FIFO_RD pulses;
  -> one FRAME_REQ without FIFO_FLUSH per frame.
REQ-031 FIFO_EMPTY forced high at HCNT=100, VCNT=10:
  -> UNDERFLOW=1 and UFCNT=1;
  -> black output for the rest of the frame with zero further reads;
  -> FIFO_FLUSH and FRAME_REQ pulse at VCNT=768;
  -> RUN resumes at the next frame.
REQ-032 CLR_ERR asserted in the same cycle as a second underflow:
  -> UNDERFLOW stays 1 and UFCNT=2.
REQ-033 HS_IN toggling:
  -> VGA_HS equals HS_IN delayed exactly 2 cycles;
  -> RST asserted mid-line forces VGA_HS=1 on the next edge.
